pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Keeps a shadow copy of the register-use info for the instructions in EX, MEM and WB.
//  From that shadow it drives the PC/IF-ID enables, the ID/EX bubble, the IF/ID flush and the EX forwarding selects.
//  Inputs come from the ID-stage decode fields. Outputs go to the pipeline registers and the EX operand muxes.
// PARAMETERS
//  FWD_EN       1   1: EX forwarding enabled; 0: no forwarding, RAW hazards resolved by stalling
//  CNT_W        16  width of stall/flush performance counters
// PORTS
//  clk            in   1      core clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  ID_valid       in   1      ID stage holds a real instruction
//  ID_rs1_addr    in   5      ID source register 1 (Inst[19:15])
//  ID_rs2_addr    in   5      ID source register 2 (Inst[24:20])
//  ID_rs1_used    in   1      ID instruction reads rs1
//  ID_rs2_used    in   1      ID instruction reads rs2
//  ID_rd_addr     in   5      ID destination (Inst[11:7])
//  ID_RegWrite    in   1      ID instruction writes rd
//  ID_MemRead     in   1      ID instruction is a load
//  EX_redirect    in   1      branch taken / jump resolved in EX this cycle
//  PC_EN_IF       out  1      PC update enable
//  en_IFID        out  1      IF/ID register enable
//  flush_IFID     out  1      IF/ID register clears to NOP next edge
//  NOP_IDEX       out  1      ID/EX register loads a bubble next edge
//  fwd_A_sel      out  2      EX operand A source: 00 regfile, 01 MEM result, 10 WB data
//  fwd_B_sel      out  2      EX operand B source, same encoding
//  stall_cnt      out  CNT_W  cycles spent in stall (saturating)
//  flush_cnt      out  CNT_W  cycles with redirect flush (saturating)
// BEHAVIOUR
//  - Shadow slots EX/MEM/WB, each holding {v, rd, wr, ld, rs1, rs2, u1, u2}.
//    Per posedge: WB<=MEM, MEM<=EX, EX<=ID info, or a bubble (v=0) when NOP_IDEX=1 or ID_valid=0.
//  - Effective write: a slot writes only when v & wr & rd!=0. rd==x0 never causes a hazard or a forward.
//  - match(S,r,u) = u & S writes & S.rd==r. ID hazard hit = match on rs1 or rs2.
//  - Hazard detection, FWD_EN=1: load-use only. ID hit against EX with EX.ld=1 -> stall.
//  - Hazard detection, FWD_EN=0: ID hit against EX or MEM -> stall.
//    No WB stall: the regfile writes before it reads within a cycle.
//  - Stall: PC_EN_IF=0, en_IFID=0, NOP_IDEX=1, flush_IFID=0. A stall lasts as long as the condition holds.
//  - Redirect: EX_redirect=1 sets PC_EN_IF=1, en_IFID=1, flush_IFID=1, NOP_IDEX=1.
//    Redirect has priority over a simultaneous stall, because the stalled ID instruction is wrong-path.
//  - Normal (no stall, no redirect): PC_EN_IF=1, en_IFID=1, flush_IFID=0, NOP_IDEX=0.
//  - Control outputs are combinational from the shadow slots and current inputs; they take effect at the next posedge.
//  - Forwarding for the instruction in the EX slot (combinational from the slots):
//    - sel=01 if MEM writes, MEM.rd==EX.rs, EX.u and MEM.ld=0.
//    - else sel=10 if WB writes, WB.rd==EX.rs and EX.u.
//    - else sel=00. MEM has priority over WB.
//    - With FWD_EN=0 both selects are 00 at all times.
//    - A MEM load matching EX is impossible after a load-use stall; the selects still return 00 in that case.
//  - Counters:
//    - stall_cnt +1 on each posedge with stall=1 and redirect=0.
//    - flush_cnt +1 on each posedge with redirect=1.
//    - Both saturate at all-ones; they never wrap.
//  - Reset, rst=1 at a posedge: all slots v=0 and counters 0.
//    While rst=1 the outputs are forced to PC_EN_IF=1, en_IFID=1, flush_IFID=0, NOP_IDEX=0, fwd=00.
//    A reset during a stall drops the stall immediately. No partial state survives.
// TESTING
//  1. lw x5,0(x0); add x6,x5,x1 back-to-back, FWD_EN=1 -> exactly 1 cycle of PC_EN_IF=0/NOP_IDEX=1.
//     Two cycles later, with add in EX: fwd_A_sel=10, fwd_B_sel=00. stall_cnt=1.
//  2. add x3,x1,x2; sub x4,x3,x3 -> no stall; with sub in EX, fwd_A_sel=fwd_B_sel=01.
//  3. add x0,x1,x2; add x7,x0,x0 -> no stall, both selects 00. Same for ID_valid=0 with matching rs fields.
//  4. Load-use stall condition with EX_redirect=1 in the same cycle -> flush_IFID=1, PC_EN_IF=1, NOP_IDEX=1.
//     stall_cnt unchanged, flush_cnt +1.
//  5. FWD_EN=0: add x3,..; or x8,x3,x1 -> 2 stall cycles, then proceeds; selects stay 00. stall_cnt=2.
//  6. rst=1 during the second stall cycle of test 5 -> next cycle PC_EN_IF=1, NOP_IDEX=0, counters 0.
//     Counter saturation checked with CNT_W=2: 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, stall/flush and forwarding control for a 5-stage pipeline
//
// Keeps a shadow of register-use info for the instructions in EX, MEM and WB and
// derives the pipeline-register enables, the ID/EX bubble, the IF/ID flush and
// the EX operand forwarding selects from it.
//
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   ID_valid                     ID stage holds a real instruction
//   ID_rs1_addr/ID_rs2_addr      ID source registers, ID_rs1_used/ID_rs2_used read flags
//   ID_rd_addr, ID_RegWrite      ID destination and write flag
//   ID_MemRead                   ID instruction is a load
//   EX_redirect                  branch/jump resolved taken in EX this cycle
//   PC_EN_IF, en_IFID            PC and IF/ID register enables
//   flush_IFID, NOP_IDEX         IF/ID clear and ID/EX bubble for the next edge
//   fwd_A_sel, fwd_B_sel         EX operand source: 00 regfile, 01 MEM result, 10 WB data
//   stall_cnt, flush_cnt         saturating stall / redirect-flush cycle counters
module pipeline_hazard_ctrl #(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic [4:0]       ID_rd_addr,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             EX_redirect,
  output logic             PC_EN_IF,
  output logic             en_IFID,
  output logic             flush_IFID,
  output logic             NOP_IDEX,
  output logic [1:0]       fwd_A_sel,
  output logic [1:0]       fwd_B_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // w is the effective write (valid & RegWrite & rd!=x0), folded in when the
  // instruction enters EX so later stages never need v/wr/rd==0 separately.
  typedef struct packed {
    logic       w;
    logic [4:0] rd;
    logic       ld;
  } dst_t;

  typedef struct packed {
    dst_t       dst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ex_t;

  typedef struct packed {
    logic       w;
    logic [4:0] rd;
  } wb_t;

  ex_t              ex_q, ex_d;
  dst_t             mem_q;
  wb_t              wb_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic id_hit_ex;
  logic id_hit_mem;
  logic stall;

  // MEM wins over WB; a matching MEM load blocks the WB fallback and yields 00,
  // since its data is not available yet.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic u,
                                         input dst_t mem, input wb_t wb);
    if (u && mem.w && (mem.rd == rs)) begin
      fwd_sel = mem.ld ? 2'b00 : 2'b01;
    end else if (u && wb.w && (wb.rd == rs)) begin
      fwd_sel = 2'b10;
    end else begin
      fwd_sel = 2'b00;
    end
  endfunction

  assign id_hit_ex  = ex_q.dst.w &
                      ((ID_rs1_used & (ex_q.dst.rd == ID_rs1_addr)) |
                       (ID_rs2_used & (ex_q.dst.rd == ID_rs2_addr)));
  assign id_hit_mem = mem_q.w &
                      ((ID_rs1_used & (mem_q.rd == ID_rs1_addr)) |
                       (ID_rs2_used & (mem_q.rd == ID_rs2_addr)));

  // WB is never a stall source: the regfile writes before it reads in a cycle.
  always_comb begin
    if (FWD_EN != 0) begin
      stall = ID_valid & id_hit_ex & ex_q.dst.ld;
    end else begin
      stall = ID_valid & (id_hit_ex | id_hit_mem);
    end
  end

  // Redirect outranks stall: the stalled ID instruction is wrong-path anyway.
  always_comb begin
    PC_EN_IF   = 1'b1;
    en_IFID    = 1'b1;
    flush_IFID = 1'b0;
    NOP_IDEX   = 1'b0;
    fwd_A_sel  = 2'b00;
    fwd_B_sel  = 2'b00;
    if (!rst) begin
      if (EX_redirect) begin
        flush_IFID = 1'b1;
        NOP_IDEX   = 1'b1;
      end else if (stall) begin
        PC_EN_IF = 1'b0;
        en_IFID  = 1'b0;
        NOP_IDEX = 1'b1;
      end
      if (FWD_EN != 0) begin
        fwd_A_sel = fwd_sel(ex_q.rs1, ex_q.u1, mem_q, wb_q);
        fwd_B_sel = fwd_sel(ex_q.rs2, ex_q.u2, mem_q, wb_q);
      end
    end
  end

  always_comb begin
    ex_d = '0;
    if (ID_valid && !NOP_IDEX) begin
      ex_d.dst.w  = ID_RegWrite & (ID_rd_addr != 5'd0);
      ex_d.dst.rd = ID_rd_addr;
      ex_d.dst.ld = ID_MemRead;
      ex_d.rs1    = ID_rs1_addr;
      ex_d.rs2    = ID_rs2_addr;
      ex_d.u1     = ID_rs1_used;
      ex_d.u2     = ID_rs2_used;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && !EX_redirect && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (EX_redirect && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q.dst;
      wb_q.w      <= mem_q.w;
      wb_q.rd     <= mem_q.rd;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ID_valid;
  logic [4:0] ID_rs1_addr;
  logic [4:0] ID_rs2_addr;
  logic       ID_rs1_used;
  logic       ID_rs2_used;
  logic [4:0] ID_rd_addr;
  logic       ID_RegWrite;
  logic       ID_MemRead;
  logic       EX_redirect;

  // index 0: FWD_EN=1, CNT_W=16; index 1: FWD_EN=0, CNT_W=2
  logic        pc  [2];
  logic        en  [2];
  logic        fl  [2];
  logic        nop [2];
  logic [1:0]  fa  [2];
  logic [1:0]  fb  [2];
  logic [15:0] sc_f, fc_f;
  logic [1:0]  sc_s, fc_s;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FWD_EN(1), .CNT_W(16)) dut_f (
    .clk(clk), .rst(rst), .ID_valid(ID_valid),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_rd_addr(ID_rd_addr), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .EX_redirect(EX_redirect),
    .PC_EN_IF(pc[0]), .en_IFID(en[0]), .flush_IFID(fl[0]), .NOP_IDEX(nop[0]),
    .fwd_A_sel(fa[0]), .fwd_B_sel(fb[0]), .stall_cnt(sc_f), .flush_cnt(fc_f)
  );

  pipeline_hazard_ctrl #(.FWD_EN(0), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .ID_valid(ID_valid),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_rd_addr(ID_rd_addr), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .EX_redirect(EX_redirect),
    .PC_EN_IF(pc[1]), .en_IFID(en[1]), .flush_IFID(fl[1]), .NOP_IDEX(nop[1]),
    .fwd_A_sel(fa[1]), .fwd_B_sel(fb[1]), .stall_cnt(sc_s), .flush_cnt(fc_s)
  );

  // Reference model: a history of the instructions that entered EX, newest last.
  // Distance 1 = EX, 2 = MEM, 3 = WB.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
  } ins_t;

  ins_t hist0[$];
  ins_t hist1[$];
  int   exp_sc [2] = '{0, 0};
  int   exp_fc [2] = '{0, 0};
  int   total = 0;
  int   bad   = 0;

  function automatic int sat_max(int k);
    return (k == 0) ? 65535 : 3;
  endfunction

  function automatic ins_t at(int k, int d);
    ins_t b = '{default: 0};
    if (k == 0) begin
      if (hist0.size() >= d) return hist0[hist0.size() - d];
    end else begin
      if (hist1.size() >= d) return hist1[hist1.size() - d];
    end
    return b;
  endfunction

  function automatic bit writes(ins_t p);
    return p.v && p.wr && (p.rd != 5'd0);
  endfunction

  // Producers within the unsafe distance of the ID consumer force a stall:
  // with forwarding only an EX load is unsafe, without it anything in EX or MEM.
  function automatic bit m_stall(int k);
    bit fwd = (k == 0);
    if (!ID_valid) return 1'b0;
    for (int d = 1; d <= (fwd ? 1 : 2); d++) begin
      ins_t p;
      p = at(k, d);
      if (writes(p) &&
          ((ID_rs1_used && p.rd == ID_rs1_addr) || (ID_rs2_used && p.rd == ID_rs2_addr)) &&
          (!fwd || p.ld))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // The nearest older producer of the EX operand decides the source.
  function automatic logic [1:0] m_fwd(int k, bit second);
    ins_t     c;
    bit [4:0] rs;
    if (k != 0) return 2'b00;
    c = at(k, 1);
    if (!(second ? c.u2 : c.u1)) return 2'b00;
    rs = second ? c.rs2 : c.rs1;
    for (int d = 2; d <= 3; d++) begin
      ins_t p;
      p = at(k, d);
      if (writes(p) && p.rd == rs) return (d == 2) ? (p.ld ? 2'b00 : 2'b01) : 2'b10;
    end
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] ectl;
      logic [1:0] efa;
      logic [1:0] efb;
      if (rst)              ectl = 4'b1100;
      else if (EX_redirect) ectl = 4'b1111;
      else if (m_stall(k))  ectl = 4'b0001;
      else                  ectl = 4'b1100;
      efa = rst ? 2'b00 : m_fwd(k, 1'b0);
      efb = rst ? 2'b00 : m_fwd(k, 1'b1);
      chk($sformatf("pc_en%0d", k), 32'(pc[k]), 32'(ectl[3]));
      chk($sformatf("en_ifid%0d", k), 32'(en[k]), 32'(ectl[2]));
      chk($sformatf("flush%0d", k), 32'(fl[k]), 32'(ectl[1]));
      chk($sformatf("nop%0d", k), 32'(nop[k]), 32'(ectl[0]));
      chk($sformatf("fwd_a%0d", k), 32'(fa[k]), 32'(efa));
      chk($sformatf("fwd_b%0d", k), 32'(fb[k]), 32'(efb));
      chk($sformatf("stall_cnt%0d", k), (k == 0) ? 32'(sc_f) : 32'(sc_s), 32'(exp_sc[k]));
      chk($sformatf("flush_cnt%0d", k), (k == 0) ? 32'(fc_f) : 32'(fc_s), 32'(exp_fc[k]));
    end
  endtask

  task automatic update();
    ins_t cur;
    ins_t bub = '{default: 0};
    cur.v = ID_valid;       cur.rd = ID_rd_addr;   cur.wr = ID_RegWrite; cur.ld = ID_MemRead;
    cur.rs1 = ID_rs1_addr;  cur.rs2 = ID_rs2_addr; cur.u1 = ID_rs1_used; cur.u2 = ID_rs2_used;
    for (int k = 0; k < 2; k++) begin
      bit   st;
      ins_t ent;
      st  = m_stall(k);
      ent = (!ID_valid || EX_redirect || st) ? bub : cur;
      if (rst) begin
        if (k == 0) hist0.delete(); else hist1.delete();
        exp_sc[k] = 0;
        exp_fc[k] = 0;
      end else begin
        if (k == 0) begin
          hist0.push_back(ent);
          if (hist0.size() > 4) hist0.delete(0);
        end else begin
          hist1.push_back(ent);
          if (hist1.size() > 4) hist1.delete(0);
        end
        if (st && !EX_redirect && exp_sc[k] < sat_max(k)) exp_sc[k]++;
        if (EX_redirect && exp_fc[k] < sat_max(k)) exp_fc[k]++;
      end
    end
  endtask

  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic id(input bit v, input bit [4:0] rd, input bit wr, input bit ld,
                    input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2);
    ID_valid = v;  ID_rd_addr = rd;   ID_RegWrite = wr; ID_MemRead = ld;
    ID_rs1_addr = rs1; ID_rs1_used = u1; ID_rs2_addr = rs2; ID_rs2_used = u2;
  endtask

  initial begin
    rst = 1'b1;
    EX_redirect = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_pc_en", 32'(pc[0]), 32'd1);
    chk("rst_nop", 32'(nop[0]), 32'd0);
    chk("rst_stall_cnt", 32'(sc_f), 32'd0);
    cyc();
    rst = 1'b0;

    // lw x5,0(x0); add x6,x5,x1
    id(1, 5, 1, 1, 0, 1, 0, 0); cyc();
    id(1, 6, 1, 0, 5, 1, 1, 1);
    #1 chk("t1_stall_pc", 32'(pc[0]), 32'd0);
    chk("t1_stall_nop", 32'(nop[0]), 32'd1);
    cyc();
    #1 chk("t1_resume_pc", 32'(pc[0]), 32'd1);
    cyc();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t1_fwd_a", 32'(fa[0]), 32'd2);
    chk("t1_fwd_b", 32'(fb[0]), 32'd0);
    chk("t1_stall_cnt", 32'(sc_f), 32'd1);
    cyc();

    // add x3,x1,x2; sub x4,x3,x3
    id(1, 3, 1, 0, 1, 1, 2, 1); cyc();
    id(1, 4, 1, 0, 3, 1, 3, 1);
    #1 chk("t2_no_stall", 32'(nop[0]), 32'd0);
    cyc();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t2_fwd_a", 32'(fa[0]), 32'd1);
    chk("t2_fwd_b", 32'(fb[0]), 32'd1);
    cyc();

    // add x0,x1,x2; add x7,x0,x0; then an invalid ID with matching fields
    id(1, 0, 1, 0, 1, 1, 2, 1); cyc();
    id(1, 7, 1, 0, 0, 1, 0, 1);
    #1 chk("t3_x0_no_stall", 32'(pc[0]), 32'd1);
    cyc();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t3_x0_fwd_a", 32'(fa[0]), 32'd0);
    chk("t3_x0_fwd_b", 32'(fb[0]), 32'd0);
    cyc();
    id(1, 9, 1, 1, 0, 1, 0, 0); cyc();
    id(0, 0, 0, 0, 9, 1, 9, 1);
    #1 chk("t3_invalid_no_stall", 32'(pc[0]), 32'd1);
    cyc();

    // load-use with a simultaneous redirect
    id(1, 5, 1, 1, 0, 1, 0, 0); cyc();
    id(1, 6, 1, 0, 5, 1, 1, 1);
    EX_redirect = 1'b1;
    #1 chk("t4_flush", 32'(fl[0]), 32'd1);
    chk("t4_pc_en", 32'(pc[0]), 32'd1);
    chk("t4_nop", 32'(nop[0]), 32'd1);
    cyc();
    EX_redirect = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t4_stall_cnt", 32'(sc_f), 32'd1);
    chk("t4_flush_cnt", 32'(fc_f), 32'd1);
    cyc();

    // no-forwarding instance: add x3,..; or x8,x3,x1
    rst = 1'b1; cyc(); rst = 1'b0;
    id(1, 3, 1, 0, 1, 1, 2, 1); cyc();
    id(1, 8, 1, 0, 3, 1, 1, 1);
    #1 chk("t5_stall1", 32'(pc[1]), 32'd0);
    cyc();
    #1 chk("t5_stall2", 32'(pc[1]), 32'd0);
    cyc();
    #1 chk("t5_proceed", 32'(pc[1]), 32'd1);
    chk("t5_fwd_a", 32'(fa[1]), 32'd0);
    cyc();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t5_stall_cnt", 32'(sc_s), 32'd2);
    cyc();

    // reset in the second stall cycle
    rst = 1'b1; cyc(); rst = 1'b0;
    id(1, 3, 1, 0, 1, 1, 2, 1); cyc();
    id(1, 8, 1, 0, 3, 1, 1, 1); cyc();
    rst = 1'b1;
    #1 chk("t6_rst_pc_en", 32'(pc[1]), 32'd1);
    chk("t6_rst_nop", 32'(nop[1]), 32'd0);
    cyc();
    rst = 1'b0;
    #1 chk("t6_after_pc_en", 32'(pc[1]), 32'd1);
    chk("t6_after_nop", 32'(nop[1]), 32'd0);
    chk("t6_after_stall_cnt", 32'(sc_s), 32'd0);
    chk("t6_after_flush_cnt", 32'(fc_s), 32'd0);
    cyc();

    // saturation of the 2-bit counter: 6 stall cycles
    for (int r = 0; r < 3; r++) begin
      id(1, 3, 1, 0, 1, 1, 2, 1); cyc();
      id(1, 8, 1, 0, 3, 1, 1, 1); cyc(); cyc(); cyc();
    end
    #1 chk("t6_sat_stall_cnt", 32'(sc_s), 32'd3);

    // randomized traffic over a small register set to provoke many hits
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      EX_redirect = ($urandom_range(0, 7) == 0);
      ID_valid    = ($urandom_range(0, 3) != 0);
      ID_rs1_addr = 5'($urandom_range(0, 3));
      ID_rs2_addr = 5'($urandom_range(0, 3));
      ID_rd_addr  = 5'($urandom_range(0, 3));
      ID_rs1_used = 1'($urandom_range(0, 1));
      ID_rs2_used = 1'($urandom_range(0, 1));
      ID_RegWrite = 1'($urandom_range(0, 1));
      ID_MemRead  = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
